// File: rtl/act_push_serializer_pkg.sv
// act_push_serializer_pkg: shared state encoding, default sizing and lane-select helper
// Contents:
//   state_t        - serializer FSM states (IDLE, SHIFT)
//   DEF_*          - default lane/word/counter widths
//   lane_lsb()     - bit offset of a lane inside a packed word
package act_ser_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_LANES      = 8;
  localparam int DEF_IDX_WIDTH  = 3;
  localparam int DEF_CNT_WIDTH  = 16;
  function automatic int unsigned lane_lsb(input int unsigned idx, input int unsigned dw);
    return idx * dw;
  endfunction
endpackage

// File: rtl/act_push_serializer_if.sv
// act_push_serializer_if: word-in / FIFO-write-out bundle of the serializer
// Signals:
//   in_valid, in_ready, in_data, in_mask - wide word handshake (upstream)
//   full, push, data_out                 - FIFO write port (downstream)
// Modports: slave = serializer side, master = environment side
interface act_push_serializer_if
  import act_ser_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES
);
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*DATA_WIDTH-1:0] in_data;
  logic [LANES-1:0]            in_mask;
  logic                        full;
  logic                        push;
  logic [DATA_WIDTH-1:0]       data_out;
  modport slave  (input in_valid, in_data, in_mask, full, output in_ready, push, data_out);
  modport master (output in_valid, in_data, in_mask, full, input in_ready, push, data_out);
endinterface

// File: rtl/act_push_serializer_next_lane.sv
// act_ser_next_lane: lowest set mask bit at or above a lane position
// Ports:
//   i_mask - per-lane nonzero flags
//   i_pos  - search start; one bit wider than a lane index so "past the last lane" is representable
//   o_idx  - lowest set lane >= i_pos (0 when none)
//   o_any  - a set lane exists at or above i_pos
module act_ser_next_lane
  import act_ser_pkg::*;
#(
  parameter int LANES     = DEF_LANES,
  parameter int IDX_WIDTH = DEF_IDX_WIDTH
) (
  input  logic [LANES-1:0]     i_mask,
  input  logic [IDX_WIDTH:0]   i_pos,
  output logic [IDX_WIDTH-1:0] o_idx,
  output logic                 o_any
);
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = LANES - 1; i >= 0; i--)
      if (i_mask[i] && (IDX_WIDTH + 1)'(i) >= i_pos) begin
        o_idx = IDX_WIDTH'(i);
        o_any = 1'b1;
      end
  end
endmodule

// File: rtl/act_push_serializer.sv
// act_push_serializer: serialises wide activation words lane-by-lane into a FIFO write port
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   Reset       - synchronous active-high clear
//   bus         - slave side of act_push_serializer_if (word handshake + FIFO push port)
//   busy        - a word is held and not fully pushed
//   pushed_cnt  - pushes since reset, wraps
// Build option: define ACT_SER_ZERO_SKIP_EN to skip lanes whose in_mask bit is 0.
module act_push_serializer
  import act_ser_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int IDX_WIDTH  = DEF_IDX_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Reset,
  act_push_serializer_if.slave bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] pushed_cnt
);
  state_t                      r_state, w_state_nxt;
  logic [LANES*DATA_WIDTH-1:0] r_shadow;
  logic [IDX_WIDTH-1:0]        r_idx, w_first, w_next;
  logic [CNT_WIDTH-1:0]        r_cnt;
  logic                        w_push, w_last, w_first_any, w_accept;
`ifdef ACT_SER_ZERO_SKIP_EN
  logic [LANES-1:0] r_mask;
  logic             w_next_any;
  act_ser_next_lane #(.LANES(LANES), .IDX_WIDTH(IDX_WIDTH)) u_first (
    .i_mask(bus.in_mask),
    .i_pos ('0),
    .o_idx (w_first),
    .o_any (w_first_any)
  );
  act_ser_next_lane #(.LANES(LANES), .IDX_WIDTH(IDX_WIDTH)) u_next (
    .i_mask(r_mask),
    .i_pos ({1'b0, r_idx} + (IDX_WIDTH + 1)'(1)),
    .o_idx (w_next),
    .o_any (w_next_any)
  );
  // the current lane is last when no captured mask bit remains above it
  assign w_last = !w_next_any;
`else
  logic w_unused_mask;
  assign w_unused_mask = ^bus.in_mask;
  assign w_first       = '0;
  assign w_first_any   = 1'b1;
  assign w_next        = r_idx + IDX_WIDTH'(1);
  assign w_last        = r_idx == IDX_WIDTH'(LANES - 1);
`endif
  always_comb begin
    w_push       = r_state == SHIFT && !bus.full && !Reset;
    // pushing the last lane frees the shadow register in the same cycle
    bus.in_ready = r_state == IDLE || (w_push && w_last);
    w_accept     = bus.in_valid && bus.in_ready && !Reset;
    // an all-zero-mask word is consumed without leaving IDLE
    w_state_nxt  = Reset ? IDLE :
                   w_accept ? (w_first_any ? SHIFT : IDLE) :
                   (w_push && w_last) ? IDLE : r_state;
    bus.push     = w_push;
    bus.data_out = r_shadow[lane_lsb(32'(r_idx), DATA_WIDTH) +: DATA_WIDTH];
    busy         = r_state == SHIFT;
    pushed_cnt   = r_cnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_shadow <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
`ifdef ACT_SER_ZERO_SKIP_EN
      r_mask   <= '0;
`endif
    end else if (Reset) begin
      r_shadow <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
`ifdef ACT_SER_ZERO_SKIP_EN
      r_mask   <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_shadow <= bus.in_data;
        r_idx    <= w_first;
`ifdef ACT_SER_ZERO_SKIP_EN
        r_mask   <= bus.in_mask;
`endif
      end else if (w_push) r_idx <= w_next;
      r_cnt <= r_cnt + CNT_WIDTH'(w_push);
    end
endmodule

// File: tb/tb_act_push_serializer.sv
// tb_act_push_serializer: directed + randomized check of act_push_serializer against a lane-queue model
module tb_act_push_serializer;
  import act_ser_pkg::*;
  localparam int DW = 4;
  localparam int L  = 8;
  localparam int CW = 4;
`ifdef ACT_SER_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif
  logic          clk = 0, rst_n = 0, Reset = 0, busy;
  logic [CW-1:0] pushed_cnt;
  act_push_serializer_if #(.DATA_WIDTH(DW), .LANES(L)) bus ();
  act_push_serializer #(.DATA_WIDTH(DW), .LANES(L), .IDX_WIDTH(3), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Reset     (Reset),
    .bus       (bus),
    .busy      (busy),
    .pushed_cnt(pushed_cnt)
  );
  always #5 clk = ~clk;
  int          n_cmp = 0, n_bad = 0, cyc = 0, model_cnt = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] log_d[$];
  int            log_c[$];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  // model: q holds the lanes of the held word still to be pushed, in push order
  bit ep, er;
  always @(negedge clk) begin
    ep = rst_n && !Reset && q.size() > 0 && !bus.full;
    er = q.size() == 0 || (q.size() == 1 && ep);
    chk("push", bus.push, ep);
    chk("in_ready", bus.in_ready, er);
    chk("busy", busy, q.size() > 0);
    chk("pushed_cnt", pushed_cnt, model_cnt % (1 << CW));
    if (q.size() > 0 && (ep || bus.full)) chk("data_out", bus.data_out, q[0]);
    if (bus.push) begin
      log_d.push_back(bus.data_out);
      log_c.push_back(cyc);
    end
    if (!rst_n || Reset) begin
      q.delete();
      model_cnt = 0;
    end else begin
      if (ep) begin
        void'(q.pop_front());
        model_cnt++;
      end
      if (bus.in_valid && er)
        for (int i = 0; i < L; i++)
          if (!ZS || bus.in_mask[i]) q.push_back(bus.in_data[i*DW +: DW]);
    end
    cyc++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_reset();
    Reset = 1;
    tick();
    Reset = 0;
  endtask
  task automatic clear_log();
    log_d.delete();
    log_c.delete();
  endtask
  task automatic send(logic [31:0] d, logic [7:0] m);
    bit ok = 0;
    bus.in_valid = 1;
    bus.in_data  = d;
    bus.in_mask  = m;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = bus.in_ready && !Reset;
      tick();
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask
  task automatic idle(int n);
    bus.in_valid = 0;
    repeat (n) tick();
  endtask
  task automatic check_seq(string nm, int n, int span);
    chk({nm, "_count"}, log_d.size(), n);
    for (int i = 0; i < n && i < log_d.size(); i++) chk({nm, "_lane"}, log_d[i], i % 16);
    if (log_c.size() >= n) chk({nm, "_span"}, log_c[n-1] - log_c[0], span);
  endtask
  int t5z[8] = '{2, 5, 7, 0, 0, 0, 0, 0};
  initial begin
    bus.in_valid = 0;
    bus.in_data  = '0;
    bus.in_mask  = '0;
    bus.full     = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_push", bus.push, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_cnt", pushed_cnt, 0);
    rst_n = 1;
    tick();
    clear_log();
    send(32'h7654_3210, 8'hFF);
    idle(12);
    check_seq("t1", 8, 7);
    chk("t1_cnt", pushed_cnt, 8);
    pulse_reset();
    clear_log();
    send(32'h7654_3210, 8'hFF);
    send(32'hFEDC_BA98, 8'hFF);
    idle(20);
    check_seq("t2", 16, 15);
    chk("t2_cnt", pushed_cnt, 0);
    pulse_reset();
    clear_log();
    send(32'h7654_3210, 8'hFF);
    bus.in_valid = 0;
    tick();
    tick();
    bus.full = 1;
    @(negedge clk);
    chk("t3_hold_data", bus.data_out, 2);
    chk("t3_hold_push", bus.push, 0);
    tick();
    tick();
    bus.full = 0;
    idle(12);
    check_seq("t3", 8, 9);
    chk("t3_cnt", pushed_cnt, 8);
    pulse_reset();
    send(32'h7654_3210, 8'hFF);
    bus.in_valid = 0;
    tick();
    tick();
    tick();
    Reset = 1;
    @(negedge clk);
    chk("t4_reset_push", bus.push, 0);
    tick();
    Reset = 0;
    @(negedge clk);
    chk("t4_cnt_cleared", pushed_cnt, 0);
    chk("t4_idle", busy, 0);
    tick();
    clear_log();
    send(32'h7654_3210, 8'hFF);
    idle(12);
    check_seq("t4", 8, 7);
    chk("t4_cnt", pushed_cnt, 8);
    pulse_reset();
    clear_log();
    send(32'h7654_3210, 8'b1010_0100);
    idle(12);
    chk("t5_count", log_d.size(), ZS ? 3 : 8);
    for (int i = 0; i < log_d.size() && i < 8; i++) chk("t5_lane", log_d[i], ZS ? t5z[i] : i);
    send(32'h7654_3210, 8'h00);
    bus.in_valid = 0;
    @(negedge clk);
    chk("t5_zero_ready", bus.in_ready, ZS ? 1 : 0);
    idle(12);
    chk("t5_zero_count", log_d.size(), ZS ? 3 : 16);
    pulse_reset();
    clear_log();
    send(32'h7654_3210, 8'hFF);
    send(32'hFEDC_BA98, 8'hFF);
    send(32'h7654_3210, 8'hFF);
    bus.in_valid = 0;
    for (int k = 0; k < 100 && log_d.size() < 17; k++) @(posedge clk);
    chk("t6_reach17", log_d.size() >= 17, 1);
    @(negedge clk);
    chk("t6_wrap", pushed_cnt, 1);
    idle(12);
    for (int k = 0; k < 3000; k++) begin
      bus.in_valid = $urandom_range(0, 99) < 60;
      bus.in_data  = $urandom;
      bus.in_mask  = 8'($urandom);
      bus.full     = $urandom_range(0, 99) < 25;
      Reset        = $urandom_range(0, 99) < 2;
      tick();
    end
    bus.full = 0;
    Reset    = 0;
    idle(15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
